wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order write-back path and a multi-cycle result source (divider, or late load return).
- The pipeline has fixed priority. Multi-cycle results queue in a 2-entry FIFO and drain in cycles where the pipeline does not write.
- A starvation counter forces a one-cycle pipeline stall so that queued results always retire.
- Exports a pending-destination mask to the hazard unit.

---
 rtl/wb_port_arbiter_pkg.sv | 20 ++
 rtl/wb_result_fifo.sv | 98 +++++++++
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 tb/tb_wb_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   XLEN       : data width of write-back values
//   REG_W      : register index width
//   REG_ZERO   : architectural zero register (x0)
//   wb_entry_t : queued multi-cycle result {live, rd, data}
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             live;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small in-order queue for multi-cycle results waiting for the write port.
//   push_i/push_entry_i : store an entry at the tail (caller guarantees !full_o)
//   pop_i               : drop the head (caller guarantees !empty_o)
//   kill_i/kill_rd_i    : mark every stored live entry with rd == kill_rd_i dead
//   head_o              : oldest stored entry
//   empty_o/full_o      : occupancy flags
//   pend_mask_o         : bit r set while a stored live entry targets r
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic             kill_i,
  input  logic [REG_W-1:0] kill_rd_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [NREGS-1:0] pend_mask_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] occ;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rptr_q];

  // Slot s is occupied when its distance from the read pointer is below the count.
  always_comb begin : occupancy
    occ = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      occ[s] = ({1'b0, PTR_W'(PTR_W'(s) - rptr_q)} < cnt_q);
    end
  end

  // The push slot is always unoccupied, so a same-cycle push is never killed.
  always_comb begin : next_state
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (kill_i) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (occ[s] && (mem_q[s].rd == kill_rd_i)) begin
          mem_d[s].live = 1'b0;
        end
      end
    end
    if (push_i) begin
      mem_d[wptr_q] = push_entry_i;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Pending mask reflects stored live entries only.
  always_comb begin : pending
    pend_mask_o = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      if (occ[s] && mem_q[s].live) begin
        pend_mask_o[mem_q[s].rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        mem_q[s] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        mem_q[s] <= mem_d[s];
      end
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// write-back path (fixed priority) and queued multi-cycle results.
//   clk, rst_n                      : clock, synchronous active-low reset
//   wb_regwrite/wb_rd/wb_data       : pipeline write-back request
//   mc_valid/mc_rd/mc_data, mc_ready: multi-cycle result handshake
//   pipe_stall                      : one-cycle forced drain, WB must hold
//   rf_we/rf_waddr/rf_wdata         : registered register-file write
//   pend_mask                       : destinations of queued live results
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mc_valid,
  output logic             mc_ready,
  input  logic [REG_W-1:0] mc_rd,
  input  logic [XLEN-1:0]  mc_data,
  output logic             pipe_stall,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREGS-1:0] pend_mask
);

  localparam int unsigned          STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                pipe_req;
  logic                fifo_push, fifo_pop, head_wr;
  logic                fifo_empty, fifo_full;
  wb_entry_t           fifo_head, push_entry;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                pipe_stall_q, pipe_stall_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_W-1:0]    rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;

  assign mc_ready   = !fifo_full;
  assign push_entry = '{live: 1'b1, rd: mc_rd, data: mc_data};

  assign pipe_stall = pipe_stall_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  // A pipeline write kills older queued results for the same register.
  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .kill_i       (pipe_req),
    .kill_rd_i    (wb_rd),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .pend_mask_o  (pend_mask)
  );

  // Grant: pipeline first (masked while stalled), else pop the head; dead heads retire silently.
  always_comb begin : grant
    pipe_req   = wb_regwrite && (wb_rd != REG_ZERO) && !pipe_stall_q;
    fifo_pop   = !pipe_req && !fifo_empty;
    head_wr    = fifo_pop && fifo_head.live;
    fifo_push  = mc_valid && mc_ready && (mc_rd != REG_ZERO);
    rf_we_d    = pipe_req || head_wr;
    rf_waddr_d = REG_ZERO;
    rf_wdata_d = '0;
    if (pipe_req) begin
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else if (head_wr) begin
      rf_waddr_d = fifo_head.rd;
      rf_wdata_d = fifo_head.data;
    end
  end

  // Count cycles a live head loses to the pipeline; reaching the limit forces one stall.
  always_comb begin : starvation
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (pipe_req && fifo_head.live && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    pipe_stall_d = (starve_d == STARVE_MAX) && !pipe_stall_q;
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      starve_q     <= '0;
      pipe_stall_q <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_q     <= starve_d;
      pipe_stall_q <= pipe_stall_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_rd = '0;
  logic [31:0] mc_data = '0;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .pipe_stall  (pipe_stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pend_mask   (pend_mask)
  );

  // Reference model state: queue of waiting results, starvation count, stall flag.
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          m_starve;
  bit          m_stall;
  bit          m_acc;
  bit          e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      wb_regwrite = 1'($urandom);
      wb_rd       = 5'($urandom);
      wb_data     = $urandom;
      mc_valid    = 1'($urandom);
      mc_rd       = 5'($urandom);
      mc_data     = $urandom;
      @(posedge clk); #1;
    end
    check_eq("rst_we", rf_we, 0);
    check_eq("rst_waddr", rf_waddr, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    check_eq("rst_stall", pipe_stall, 0);
    check_eq("rst_pend", pend_mask, 0);
    check_eq("rst_ready", mc_ready, 1);
    mq.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_acc    = 1'b0;
    rst_n    = 1'b1;
  endtask

  // One clock: drive inputs (WB held while stalled), advance the model, compare after the edge.
  task automatic step(input bit rw, input logic [4:0] rd, input logic [31:0] d,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bit    ready, preq;
    ment_t h;
    if (!m_stall) begin
      wb_regwrite = rw;
      wb_rd       = rd;
      wb_data     = d;
    end
    mc_valid = mv;
    mc_rd    = mrd;
    mc_data  = md;
    ready = (mq.size() < DEPTH);
    check_eq("mc_ready", mc_ready, ready);
    preq = wb_regwrite && (wb_rd != 0) && !m_stall;
    e_we = 0; e_waddr = '0; e_wdata = '0;
    if (mq.size() == 0) m_starve = 0;
    else if (preq && mq[0].live && m_starve < LIMIT) m_starve++;
    if (preq) begin
      e_we = 1; e_waddr = wb_rd; e_wdata = wb_data;
      foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 0;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_starve = 0;
      if (h.live) begin
        e_we = 1; e_waddr = h.rd; e_wdata = h.data;
      end
    end
    m_acc = mv && ready;
    if (m_acc && mrd != 0) mq.push_back('{live: 1'b1, rd: mrd, data: md});
    m_stall = (m_starve == LIMIT) && !m_stall;
    @(posedge clk); #1;
    check_eq("rf_we", rf_we, e_we);
    if (e_we) begin
      check_eq("rf_waddr", rf_waddr, e_waddr);
      check_eq("rf_wdata", rf_wdata, e_wdata);
    end
    check_eq("pipe_stall", pipe_stall, m_stall);
    check_eq("pend_mask", pend_mask, model_mask());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          hv;
    logic [4:0]  hrd;
    logic [31:0] hd;
    bit          rw;
    logic [4:0]  rd;
    hv = 0; hrd = '0; hd = '0;

    do_reset(2);
    step(0, 0, 0, 0, 0, 0);
    check_eq("idle_we", rf_we, 0);

    // Pipeline-only writes, including x0.
    step(1, 5, 32'h1234, 0, 0, 0);
    check_eq("pipe_waddr", rf_waddr, 5);
    check_eq("pipe_wdata", rf_wdata, 32'h1234);
    step(1, 0, 32'h1234, 0, 0, 0);
    check_eq("x0_we", rf_we, 0);

    // Multi-cycle result drains in an idle cycle.
    step(0, 0, 0, 1, 7, 32'hA5);
    check_eq("pend7_set", pend_mask[7], 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("mc_waddr", rf_waddr, 7);
    check_eq("mc_wdata", rf_wdata, 32'hA5);
    check_eq("pend7_clr", pend_mask[7], 0);

    // Fill under continuous pipe traffic, then starvation forces one stall.
    step(1, 3, 32'h300, 1, 10, 32'hA10);
    step(1, 4, 32'h400, 1, 11, 32'hB11);
    check_eq("full_ready", mc_ready, 0);
    step(1, 5, 32'h500, 1, 12, 32'hC12);
    step(1, 6, 32'h600, 1, 12, 32'hC12);
    step(1, 13, 32'h1300, 1, 12, 32'hC12);
    check_eq("starve_stall", pipe_stall, 1);
    step(1, 13, 32'h1300, 1, 12, 32'hC12);
    check_eq("drain_waddr", rf_waddr, 10);
    check_eq("drain_wdata", rf_wdata, 32'hA10);
    check_eq("stall_once", pipe_stall, 0);
    step(1, 13, 32'h1300, 1, 12, 32'hC12);
    check_eq("held_waddr", rf_waddr, 13);
    check_eq("held_wdata", rf_wdata, 32'h1300);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

    // Kill: a newer pipeline write to r9 retires the queued r9 result silently.
    step(0, 0, 0, 1, 9, 32'h77);
    step(1, 9, 32'h55, 0, 0, 0);
    check_eq("kill_pend9", pend_mask[9], 0);
    check_eq("kill_wdata", rf_wdata, 32'h55);
    step(0, 0, 0, 0, 0, 0);
    check_eq("kill_no_we", rf_we, 0);

    // Entry pushed in the same cycle as a pipeline write to r9 survives.
    step(1, 9, 32'h66, 1, 9, 32'h88);
    check_eq("same_cyc_pend9", pend_mask[9], 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("same_cyc_wdata", rf_wdata, 32'h88);

    // Random traffic; multi-cycle requests hold until accepted.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 3));
        hv = 0;
      end else begin
        if (!hv) begin
          hv  = ($urandom_range(0, 2) == 0);
          hrd = 5'($urandom_range(0, 7));
          hd  = $urandom;
        end
        rw = ($urandom_range(0, 3) != 0);
        rd = 5'($urandom_range(0, 7));
        step(rw, rd, $urandom, hv, hrd, hd);
        if (m_acc) hv = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
